// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INST_DEF = 16'h0000;
    localparam int          BYTE_W       = 8;

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction storage: synchronous write port, asynchronous read port, no reset on contents.
module imem_loader_ram
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder with a valid/ready program loader that holds the core in reset.
// Optional byte-wide load port enabled by defining IMEM_BYTE_LOAD_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 128,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              cpu_rst_n_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   load_cnt_o
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   load_cnt;
    logic              done_r;
    logic              cpu_rst_n_r;
    logic              accept;
    logic              we;
    logic              complete;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    assign load_ready_o = (state == LOAD);
    // A restart request wins over a beat offered in the same cycle.
    assign accept       = load_valid_i & load_ready_o & ~load_start_i;

`ifdef IMEM_BYTE_LOAD_EN
    logic              byte_hi;
    logic [BYTE_W-1:0] low_byte;
    logic              unused_hi_bits;

    assign unused_hi_bits = ^load_data_i[DATA_W-1:BYTE_W];

    // A last beat landing on the low phase still commits a zero-extended word.
    always_comb begin
        we    = accept & (byte_hi | load_last_i);
        wdata = byte_hi ? DATA_W'({load_data_i[BYTE_W-1:0], low_byte})
                        : DATA_W'(load_data_i[BYTE_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_hi <= 1'b0;
        end else if (load_start_i) begin
            byte_hi <= 1'b0;
        end else if (accept) begin
            byte_hi <= ~byte_hi & ~load_last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !byte_hi) begin
            low_byte <= load_data_i[BYTE_W-1:0];
        end
    end
`else
    always_comb begin
        we    = accept;
        wdata = load_data_i;
    end
`endif

    assign complete = we & (load_last_i | (waddr == ADDR_W'(DEPTH - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load_start_i) state_nxt = LOAD;
            LOAD: begin
                if (load_start_i) begin
                    state_nxt = LOAD;
                end else if (complete) begin
                    state_nxt = RUN;
                end
            end
            RUN:  if (load_start_i) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Write pointer saturates on the last word; the FSM leaves LOAD on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr       <= '0;
            load_cnt    <= '0;
            done_r      <= 1'b0;
            cpu_rst_n_r <= 1'b0;
        end else begin
            done_r      <= complete;
            cpu_rst_n_r <= (state == RUN);
            if (load_start_i) begin
                waddr    <= '0;
                load_cnt <= '0;
            end else if (we) begin
                load_cnt <= load_cnt + 1'b1;
                if (waddr != ADDR_W'(DEPTH - 1)) begin
                    waddr <= waddr + 1'b1;
                end
            end
        end
    end

    imem_loader_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (inst_addr_i),
        .rdata (rdata)
    );

    assign inst_o      = (state == RUN) ? rdata : NOP_INST;
    assign cpu_rst_n_o = cpu_rst_n_r;
    assign load_done_o = done_r;
    assign load_cnt_o  = load_cnt;

endmodule
